// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit: steps T-states and emits one
// register-transfer control pattern per state, decoded from state and IR.
module control_sequencer #(
    parameter int OPW = 5,
    parameter int RIW = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            mem_rdy,
    input  logic [31:0]     instr_in,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic            mem_read,
    output logic            inc_pc,
    output logic [8:0]      bus_src,
    output logic [RIW-1:0]  rf_read_idx,
    output logic [9:0]      wr_en,
    output logic            RF_enable,
    output logic [RIW-1:0]  RF_write,
    output logic [12:0]     alu_sel
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    localparam logic [OPW-1:0] OP_MUL = OPW'(4);
    localparam logic [OPW-1:0] OP_DIV = OPW'(5);
    localparam logic [OPW-1:0] OP_NEG = OPW'(11);
    localparam logic [OPW-1:0] OP_NOT = OPW'(12);
    localparam logic [OPW-1:0] OP_IN  = OPW'(13);
    localparam logic [OPW-1:0] OP_OUT = OPW'(14);
    localparam logic [OPW-1:0] OP_NOP = OPW'(15);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [OPW-1:0] opcode;
    logic [RIW-1:0] ra, rb, rc;
    logic           op_unary, op_muldiv, op_illegal;
    logic [12:0]    alu_dec;
    state_t         state_final;
    logic           unused_ir_bits;

    assign opcode = ir_q[31 -: OPW];
    assign ra     = ir_q[31-OPW -: RIW];
    assign rb     = ir_q[31-OPW-RIW -: RIW];
    assign rc     = ir_q[31-OPW-2*RIW -: RIW];
    assign unused_ir_bits = ^ir_q[31-OPW-3*RIW:0];

    assign op_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign op_muldiv  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign op_illegal = (opcode > OP_NOP);

    // Opcodes 0..12 map directly onto the one-hot ALU select bit positions.
    genvar gi;
    generate
        for (gi = 0; gi < 13; gi++) begin : g_alu_dec
            assign alu_dec[gi] = (opcode == OPW'(gi));
        end
    endgenerate

    // Start held in a final state chains straight into the next fetch.
    assign state_final = start ? S_T0 : S_IDLE;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        illegal     = 1'b0;
        mem_read    = 1'b0;
        inc_pc      = 1'b0;
        bus_src     = '0;
        rf_read_idx = '0;
        wr_en       = '0;
        RF_enable   = 1'b0;
        RF_write    = '0;
        alu_sel     = '0;

        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                bus_src[0] = 1'b1;
                wr_en[2]   = 1'b1;
                wr_en[7]   = 1'b1;
                inc_pc     = 1'b1;
                state_d    = S_T1;
            end
            S_T1: begin
                mem_read   = 1'b1;
                bus_src[6] = 1'b1;
                wr_en[0]   = 1'b1;
                if (mem_rdy) begin
                    wr_en[1] = 1'b1;
                    ir_d     = instr_in;
                    state_d  = S_T2;
                end
            end
            S_T2: begin
                if (op_illegal) begin
                    illegal = 1'b1;
                    state_d = state_final;
                end else if (opcode == OP_NOP) begin
                    done    = 1'b1;
                    state_d = state_final;
                end else if (op_unary) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3: begin
                if (opcode == OP_IN) begin
                    bus_src[2] = 1'b1;
                    RF_enable  = 1'b1;
                    RF_write   = ra;
                    done       = 1'b1;
                    state_d    = state_final;
                end else if (opcode == OP_OUT) begin
                    bus_src[8]  = 1'b1;
                    rf_read_idx = ra;
                    wr_en[3]    = 1'b1;
                    done        = 1'b1;
                    state_d     = state_final;
                end else begin
                    bus_src[8]  = 1'b1;
                    rf_read_idx = rb;
                    wr_en[9]    = 1'b1;
                    state_d     = S_T4;
                end
            end
            S_T4: begin
                bus_src[8]  = 1'b1;
                rf_read_idx = op_unary ? rb : rc;
                alu_sel     = alu_dec;
                wr_en[7]    = 1'b1;
                wr_en[6]    = op_muldiv;
                state_d     = S_T5;
            end
            S_T5: begin
                bus_src[6] = 1'b1;
                if (op_muldiv) begin
                    wr_en[5] = 1'b1;
                    state_d  = S_T6;
                end else begin
                    RF_enable = 1'b1;
                    RF_write  = ra;
                    done      = 1'b1;
                    state_d   = state_final;
                end
            end
            S_T6: begin
                bus_src[5] = 1'b1;
                wr_en[4]   = 1'b1;
                done       = 1'b1;
                state_d    = state_final;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the datapath's bus-source selects, register write enables, register-file controls and ALU op selects. It replaces the bench-driven control signals. It fetches an instruction via MAR/MDR, latches it into an internal IR, and steps through T-states. Each T-state asserts the one-hot control pattern for one register-transfer step.

Parameters:
OPW, 5, opcode field width (IR[31:27])
RIW, 4, register index field width

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
start  in  1  begin fetch/execute of next instruction when idle
mem_rdy  in  1  memory read data valid this cycle
instr_in  in  32  instruction word from memory; sampled when mem_rdy=1 in T1
busy  out  1  high in every state except IDLE
done  out  1  high during final execute state of a legal instruction
illegal  out  1  one-cycle pulse in T2 for an undefined opcode
mem_read  out  1  memory read request
inc_pc  out  1  ALU computes bus+1 into Z
bus_src  out  9  one-hot bus driver: [0]PC [1]MDR [2]InPort [3]HI [4]LO [5]ZHI [6]ZLO [7]C [8]register file
rf_read_idx  out  4  register driven on bus when bus_src[8]=1
wr_en  out  10  write enables: [0]PC [1]MDR [2]MAR [3]OutPort [4]HI [5]LO [6]ZHI [7]ZLO [8]C [9]RY
RF_enable  out  1  register-file write enable
RF_write  out  4  register-file write index
alu_sel  out  13  one-hot: [0]AND [1]OR [2]ADD [3]SUB [4]MUL [5]DIV [6]SHR [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT

Behaviour:
- Fixed: single clock clk; reset clr is synchronous and active-high.
- Instruction fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcode map:
  - 0-12: ALU ops in alu_sel bit order.
  - 11 NEG and 12 NOT are unary.
  - 13 IN, 14 OUT, 15 NOP.
  - 16-31 are illegal.
- Outputs are a Moore decode of the registered state and IR; all outputs are 0 unless listed below.
- Reset: on a clk edge with clr=1, state=IDLE, IR=0, and all outputs are 0. clr takes priority over everything, including mid-instruction; no partial-step completion.
- IDLE: if start=1, go to T0 on the next cycle.
- T0: bus_src[0], wr_en[2], inc_pc, wr_en[7] -> T1.
- T1:
  - Asserts mem_read, bus_src[6], wr_en[0] (rewriting PC from ZLO is idempotent).
  - While mem_rdy=0: stay in T1, wr_en[1]=0.
  - When mem_rdy=1: wr_en[1]=1, IR<=instr_in, go to T2.
- T2 (decode):
  - Illegal opcode: illegal=1 -> IDLE.
  - NOP: done=1 -> IDLE.
  - Binary ALU op -> T3.
  - Unary ALU op -> T4.
  - IN/OUT -> T3.
- T3:
  - Binary ALU: bus_src[8], rf_read_idx=Rb, wr_en[9] -> T4.
  - IN: bus_src[2], RF_enable, RF_write=Ra, done -> IDLE.
  - OUT: bus_src[8], rf_read_idx=Ra, wr_en[3], done -> IDLE.
- T4:
  - Drives bus_src[8], the opcode's alu_sel bit, and wr_en[7].
  - rf_read_idx=Rc for binary ops, Rb for unary ops.
  - MUL/DIV additionally assert wr_en[6].
  - -> T5.
- T5:
  - Drives bus_src[6].
  - Non-MUL/DIV: RF_enable, RF_write=Ra, done -> IDLE.
  - MUL/DIV: wr_en[5] -> T6.
- T6 (MUL/DIV only): bus_src[5], wr_en[4], done -> IDLE.
- Back-to-back: if start=1 in the final state (done=1, or the illegal T2), the next state is T0 instead of IDLE.
- start is ignored in all states other than IDLE and the final state.
- Invariants: bus_src and alu_sel are each one-hot or zero in every cycle; at most one RF write per instruction.
- Latency, counted from the cycle start is sampled in IDLE to done, with mem_rdy=1:
  - NOP: 3 cycles.
  - IN/OUT: 4 cycles.
  - Binary ALU: 6 cycles.
  - Unary ALU: 5 cycles.
  - MUL/DIV: 7 cycles.
  - Add 1 cycle per mem_rdy=0 cycle in T1.

Test Plan:
- Reset: assert clr 2 cycles mid-run, release -> busy=0, all outputs 0, state IDLE; start=0 keeps it idle.
- ADD R3,R1,R2: instr 0x11890000, mem_rdy=1 -> T3 rf_read_idx=1 with wr_en[9]; T4 rf_read_idx=2, alu_sel[2], wr_en[7]; T5 RF_write=3 with done=1 on the 6th cycle.
- MUL R1,R2: instr 0x20090000 -> T4 asserts alu_sel[4], wr_en[7:6]; T5 wr_en[5]; T6 bus_src[5], wr_en[4], done on the 7th cycle; RF_enable never asserted.
- Memory stall: mem_rdy low 3 cycles then high -> T1 lasts 4 cycles; wr_en[1] only in the last; IR captures instr_in from that cycle only.
- Illegal: instr 0xF8000000 -> illegal=1 for exactly one cycle in T2, done=0, then IDLE. IN (0x69800000) -> bus_src[2], RF_write=3, done in cycle 4.
- Back-to-back and abort: start held high across two NOPs (0x78000000) -> T0 immediately follows the first done with no IDLE cycle; clr asserted in T4 of ADD -> all outputs 0 on the next cycle, no RF write.
